// File: rtl/nios_jtag_pkg.sv
// Shared definitions for the JTAG host TAP master.
// Holds op codes, host FSM states, TMS sequences and the default scan length.
package nios_jtag_pkg;

    localparam int MAX_LEN = 64;

    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_DR  = 2'd2;
    localparam logic [1:0] OP_RTI = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TRST,
        S_SEL_DR,
        S_SEL_IR,
        S_CAPTURE,
        S_SHIFT,
        S_EXIT1,
        S_UPDATE,
        S_RTI_RUN,
        S_DONE
    } state_t;

    // TMS sequences, bit 0 is sent first
    localparam int         RST_TCKS   = 6;
    localparam logic [5:0] TMS_RST    = 6'b011111;
    localparam logic [2:0] TMS_DR_PRE = 3'b001;
    localparam logic [3:0] TMS_IR_PRE = 4'b0011;
    localparam logic [1:0] TMS_POST   = 2'b01;

endpackage

// File: rtl/nios_jtag_tck_gen.sv
// TCK divider: toggles o_tck every CLK_DIV clk cycles while i_en is high.
// Ports: i_clk, i_reset, i_en in; o_tck, o_rise_tick, o_fall_tick out.
module nios_jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tck;
    logic          w_tick;

    assign w_tick      = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise_tick = w_tick && !r_tck;
    assign o_fall_tick = w_tick && r_tck;
    assign o_tck       = r_tck;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nios_jtag_tap_master.sv
// JTAG host TAP master: runs TAP reset, IR/DR scans and idle clocking.
// Ports: cmd_* request, rsp_* completion, tck/tms/tdi/tdo to the target TAP.
module nios_jtag_tap_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = nios_jtag_pkg::MAX_LEN,
    parameter int LEN_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    import nios_jtag_pkg::*;

    state_t             r_state;
    state_t             w_nstate;
    logic [LEN_W-1:0]   r_bit;
    logic [LEN_W-1:0]   w_nbit;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len;
    logic [1:0]         r_op;
    logic               r_known;
    logic               r_tms;
    logic               r_tdi;
    logic [MAX_LEN-1:0] r_dsh;
    logic [MAX_LEN-1:0] w_dsh;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_rsp;
    logic               w_accept;
    logic               w_adv;
    logic               w_run;
    logic               w_rise;
    logic               w_fall;

    function automatic state_t op_start(
        input logic [1:0]       op,
        input logic [LEN_W-1:0] len
    );
        if (op == OP_IR || op == OP_DR) return S_SEL_DR;
        if (op == OP_RTI && len != '0) return S_RTI_RUN;
        return S_DONE;
    endfunction

    function automatic logic tms_of(
        input state_t           s,
        input logic [LEN_W-1:0] b,
        input logic [LEN_W-1:0] len
    );
        logic t;
        t = 1'b0;
        unique case (s)
            S_TRST:    t = TMS_RST[b[2:0]];
            S_SEL_DR:  t = TMS_DR_PRE[0];
            S_SEL_IR:  t = TMS_IR_PRE[1];
            S_CAPTURE: t = TMS_DR_PRE[1];
            S_SHIFT:   t = (b == len - LEN_W'(1));
            S_EXIT1:   t = TMS_POST[0];
            S_UPDATE:  t = TMS_POST[1];
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_data  = r_rsp;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_run     = !(r_state == S_IDLE || r_state == S_DONE);

    nios_jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_en       (w_run),
        .o_tck      (tck),
        .o_rise_tick(w_rise),
        .o_fall_tick(w_fall)
    );

    // Scan ops clamp to 1..MAX_LEN; idle clocks take the raw count
    always_comb begin
        w_len = cmd_len;
        if (cmd_op != OP_RTI) begin
            if (cmd_len == '0)
                w_len = LEN_W'(1);
            else if (cmd_len > LEN_W'(MAX_LEN))
                w_len = LEN_W'(MAX_LEN);
        end
    end

    // TDI source: loaded at accept, shifted after each shift TCK
    always_comb begin
        w_dsh = r_dsh;
        if (w_accept)
            w_dsh = cmd_data;
        else if (w_fall && r_state == S_SHIFT)
            w_dsh = r_dsh >> 1;
    end

    // State names the TCK in progress; advancing on fall_tick picks
    // the next TCK so its tms/tdi are registered on that same edge.
    always_comb begin
        w_nstate = r_state;
        w_nbit   = r_bit;
        w_adv    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_adv  = 1'b1;
                    w_nbit = '0;
                    if (!r_known || cmd_op == OP_RST)
                        w_nstate = S_TRST;
                    else
                        w_nstate = op_start(cmd_op, w_len);
                end
            end
            S_DONE: begin
                w_adv    = 1'b1;
                w_nstate = S_IDLE;
            end
            default: begin
                if (w_fall) begin
                    w_adv  = 1'b1;
                    w_nbit = '0;
                    case (r_state)
                        S_TRST: begin
                            if (r_bit == LEN_W'(RST_TCKS - 1))
                                w_nstate = op_start(r_op, r_len);
                            else
                                w_nbit = r_bit + LEN_W'(1);
                        end
                        S_SEL_DR:
                            w_nstate = (r_op == OP_IR) ? S_SEL_IR : S_CAPTURE;
                        S_SEL_IR:
                            w_nstate = S_CAPTURE;
                        S_CAPTURE: begin
                            if (r_bit == LEN_W'(1))
                                w_nstate = S_SHIFT;
                            else
                                w_nbit = r_bit + LEN_W'(1);
                        end
                        S_SHIFT: begin
                            if (r_bit == r_len - LEN_W'(1))
                                w_nstate = S_EXIT1;
                            else
                                w_nbit = r_bit + LEN_W'(1);
                        end
                        S_EXIT1:
                            w_nstate = S_UPDATE;
                        S_UPDATE:
                            w_nstate = S_DONE;
                        S_RTI_RUN: begin
                            if (r_bit == r_len - LEN_W'(1))
                                w_nstate = S_DONE;
                            else
                                w_nbit = r_bit + LEN_W'(1);
                        end
                        default:
                            w_nstate = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_len   <= '0;
            r_op    <= OP_RST;
            r_known <= 1'b0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
            r_dsh   <= '0;
            r_cap   <= '0;
            r_rsp   <= '0;
        end else begin
            if (w_adv) begin
                r_state <= w_nstate;
                r_bit   <= w_nbit;
                r_dsh   <= w_dsh;
                r_tms   <= tms_of(w_nstate, w_nbit, r_len);
                r_tdi   <= (w_nstate == S_SHIFT) && w_dsh[0];
            end
            if (w_accept) begin
                r_op    <= cmd_op;
                r_len   <= w_len;
                r_known <= 1'b1;
                r_cap   <= '0;
            end
            if (w_rise && r_state == S_SHIFT) begin
                for (int i = 0; i < MAX_LEN; i++)
                    if (r_bit == LEN_W'(i))
                        r_cap[i] <= tdo;
            end
            // Direct IDLE->DONE (zero idle clocks) must not leak old data
            if (w_adv && w_nstate == S_DONE)
                r_rsp <= (r_state == S_IDLE) ? '0 : r_cap;
        end
    end

endmodule

// File: tb/tb_nios_jtag_tap_master.sv
// Directed bench for nios_jtag_tap_master against a 16-state TAP model.
// Target: 2-bit IR, 38-bit DR, 1-bit bypass DR when IR is all ones.
module tb_nios_jtag_tap_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam logic [37:0] CAP_DR = 38'h12_3456_789A;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               cmd_ready;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios_jtag_tap_master #(
        .CLK_DIV(CLK_DIV),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_t;

    tap_t        st = TLR;
    logic [1:0]  ir = 2'b01;
    logic [1:0]  irs = 2'b00;
    logic [37:0] dr = '0;
    logic [37:0] upd = '0;
    logic        byp = 1'b0;
    int          n_tck = 0;
    int          n_shdr = 0;
    int          n_tms1 = 0;
    int          n_tdi_bad = 0;
    int          n_rsp = 0;

    always @(posedge clk)
        if (rsp_valid === 1'b1) n_rsp <= n_rsp + 1;

    always @(posedge tck) begin
        n_tck <= n_tck + 1;
        if (tms) n_tms1 <= n_tms1 + 1;
        if (tdi && st != SHDR && st != SHIR) n_tdi_bad <= n_tdi_bad + 1;
        case (st)
            TLR:   begin ir <= 2'b01; st <= tms ? TLR : RTI; end
            RTI:   st <= tms ? SELDR : RTI;
            SELDR: st <= tms ? SELIR : CAPDR;
            CAPDR: begin
                if (ir == 2'b11) byp <= 1'b0;
                else dr <= CAP_DR;
                st <= tms ? EX1DR : SHDR;
            end
            SHDR: begin
                n_shdr <= n_shdr + 1;
                if (ir == 2'b11) byp <= tdi;
                else dr <= {tdi, dr[37:1]};
                st <= tms ? EX1DR : SHDR;
            end
            EX1DR: st <= tms ? UPDR : PADR;
            PADR:  st <= tms ? EX2DR : PADR;
            EX2DR: st <= tms ? UPDR : SHDR;
            UPDR:  begin upd <= dr; st <= tms ? SELDR : RTI; end
            SELIR: st <= tms ? TLR : CAPIR;
            CAPIR: begin irs <= 2'b01; st <= tms ? EX1IR : SHIR; end
            SHIR:  begin irs <= {tdi, irs[1]}; st <= tms ? EX1IR : SHIR; end
            EX1IR: st <= tms ? UPIR : PAIR;
            PAIR:  st <= tms ? EX2IR : PAIR;
            EX2IR: st <= tms ? UPIR : SHIR;
            UPIR:  begin ir <= irs; st <= tms ? SELDR : RTI; end
            default: st <= TLR;
        endcase
    end

    always @(negedge tck) begin
        if (st == SHDR) tdo <= (ir == 2'b11) ? byp : dr[0];
        else if (st == SHIR) tdo <= irs[0];
        else tdo <= 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          lat;
    int          dtck;
    int          dshift;
    int          dtms1;
    logic [63:0] rsp;

    task automatic wait_rsp(input string tag);
        lat = 1;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        check(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [LEN_W-1:0] len,
                       input logic [63:0] data, input string tag);
        int t0, s0, m0, k;
        @(negedge clk);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk);
        t0 = n_tck;
        s0 = n_shdr;
        m0 = n_tms1;
        #1 cmd_valid = 1'b0;
        wait_rsp(tag);
        dtck   = n_tck - t0;
        dshift = n_shdr - s0;
        dtms1  = n_tms1 - m0;
        rsp    = rsp_data;
    endtask

    initial begin
        int first_rsp, first_rdy, s0, k, r0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        reset = 1'b0;

        run(2'd2, 7'd8, 64'hA5, "t1_rsp_seen");
        check("t1_lat", lat, 77);
        check("t1_tcks", dtck, 19);
        check("t1_shifts", dshift, 8);
        check("t1_rsp", rsp, 64'h9A);
        check("t1_dr", upd[37:30], 8'hA5);
        check("t1_ready_in_rsp", cmd_ready, 0);
        @(negedge clk);
        check("t1_pulse", rsp_valid, 0);
        check("t1_ready_after", cmd_ready, 1);
        check("t1_tms_idle", tms, 0);
        check("t1_rti", st == RTI, 1);

        run(2'd0, 7'd0, 64'h0, "t2_rst_seen");
        check("t2_rst_lat", lat, 25);
        check("t2_rst_tcks", dtck, 6);
        check("t2_rst_rsp", rsp, 0);
        run(2'd1, 7'd2, 64'h3, "t2_ir_seen");
        check("t2_ir_tcks", dtck, 8);
        check("t2_ir_lat", lat, 33);
        check("t2_ir_rsp", rsp, 64'h1);
        check("t2_ir_val", ir, 2'b11);
        check("t2_ir_rti", st == RTI, 1);
        check("t2_ir_tms", tms, 0);

        run(2'd2, 7'd38, 64'h2A, "t3_seen");
        check("t3_tcks", dtck, 43);
        check("t3_shifts", dshift, 38);
        check("t3_rsp", rsp, 64'h54);

        run(2'd3, 7'd0, 64'h0, "t4a_seen");
        check("t4a_lat", lat, 1);
        check("t4a_tcks", dtck, 0);
        run(2'd3, 7'd5, 64'h0, "t4b_seen");
        check("t4b_tcks", dtck, 5);
        check("t4b_tms1", dtms1, 0);
        check("t4b_lat", lat, 21);
        check("t4b_rsp", rsp, 0);

        run(2'd2, 7'd0, 64'h1, "t5a_seen");
        check("t5a_shifts", dshift, 1);
        check("t5a_tcks", dtck, 6);
        check("t5a_rsp", rsp, 0);
        run(2'd2, 7'd100, {64{1'b1}}, "t5b_seen");
        check("t5b_shifts", dshift, 64);
        check("t5b_tcks", dtck, 69);
        check("t5b_rsp", rsp, 64'hFFFF_FFFF_FFFF_FFFE);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_len   = 7'd3;
        cmd_data  = '0;
        first_rsp = 0;
        first_rdy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && first_rsp == 0) first_rsp = i;
            if (cmd_ready === 1'b1) begin
                first_rdy = i;
                break;
            end
        end
        check("busy_rsp_cycle", first_rsp, 13);
        check("busy_ready_cycle", first_rdy, 14);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp("busy_second_seen");
        check("busy_second_lat", lat, 13);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 7'd32;
        cmd_data  = 64'hDEAD_BEEF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        s0 = n_shdr;
        k = 0;
        while ((n_shdr - s0) < 10 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_shift", (n_shdr - s0) >= 10, 1);
        r0 = n_rsp;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_tck", tck, 0);
        check("t6_tms", tms, 1);
        check("t6_tdi", tdi, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        check("t6_no_rsp", n_rsp - r0, 0);
        run(2'd2, 7'd8, 64'hA5, "t6_next_seen");
        check("t6_next_tcks", dtck, 19);
        check("t6_next_lat", lat, 77);
        check("t6_next_rsp", rsp, 64'h9A);
        check("t6_next_dr", upd[37:30], 8'hA5);

        check("tdi_outside_shift", n_tdi_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_jtag_tap_master.md
# nios_jtag_tap_master

JTAG host-side TAP controller that drives TCK/TMS/TDI and samples TDO to perform IR scans, DR scans, TAP resets and Run-Test/Idle clocking on an attached target TAP, such as the Nios II debug module's 2-bit-IR virtual JTAG port. It sits in the system clock domain behind a simple command/response handshake. It lets on-chip logic or a bench drive debug-module scans without an external JTAG cable.

## Interface
Parameters:
- CLK_DIV, 4, TCK half-period in clk cycles (≥1); one TCK period = 2*CLK_DIV clk cycles
- MAX_LEN, 64, maximum scan length in bits
- LEN_W, 7, width of cmd_len (must hold MAX_LEN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, accepts command
- cmd_op  in  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks
- cmd_len  in  LEN_W  scan bits (ops 1/2) or TCK count (op 3)
- cmd_data  in  MAX_LEN  TDI bits, bit 0 shifted first
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_data  out  MAX_LEN  captured TDO, bit 0 = first sampled; upper bits zero
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

## Operation
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, tck=0, tms=1, tdi=0; internal tap_known=0.
- Handshake: accept when cmd_valid && cmd_ready; cmd_ready drops the next cycle and stays low until rsp_valid, then rises the cycle after rsp_valid.
- Command fields are latched at accept. rsp_data holds until the next rsp_valid.
- Clamping: for ops 1/2, cmd_len 0 is treated as 1 and cmd_len > MAX_LEN as MAX_LEN. For op 3, cmd_len 0 gives zero TCKs and rsp_valid 1 cycle after accept.
- States: IDLE, TRST, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI_RUN, DONE.
- TMS sequences, one TMS value per TCK, starting from Run-Test/Idle:
  - TAP reset: 1,1,1,1,1,0. Sets tap_known=1.
  - DR scan: 1,0,0, then N shift TCKs (TMS=0 except the last, which is 1), then 1,0. Total N+5 TCKs.
  - IR scan: 1,1,0,0, then N shift TCKs as above, then 1,0. Total N+6 TCKs.
  - Idle clocks: cmd_len TCKs with TMS=0.
- If tap_known=0 when an op 1/2/3 is accepted, the 6-TCK reset sequence is prepended automatically and tap_known is set.
- tdi carries cmd_data[i] during shift TCK i and is 0 in all other TCKs.
- TDO is sampled on the tck rising edge of each shift TCK into rsp_data[i]. Ops 0 and 3 return rsp_data=0.
- Reset asserted mid-command: the command is aborted the same cycle, outputs return to reset values, tap_known is cleared, and no rsp_valid is issued.

## Timing
- The tck_gen sub-module produces fall_tick and rise_tick, alternating, every CLK_DIV clk cycles once a command is running. tck is held low while IDLE.
- The first TCK rising edge comes CLK_DIV cycles after the cycle in which tms/tdi are first driven. tms/tdi are set in the accept cycle +1 for the first TCK.
- tms/tdi change only on the clk cycle where tck goes low (fall_tick), so they are stable for a full TCK half-period before each rise.
- tdo is sampled on the clk cycle where tck goes high (rise_tick).
- Completion: the final TCK's fall_tick returns tck to 0 and asserts rsp_valid in that same cycle.
- Command latency from accept to rsp_valid = 1 + 2*CLK_DIV*(TCK count) clk cycles.
- tms is held at its last value (0, i.e. Run-Test/Idle) between commands.

## Structure
- Shared package nios_jtag_pkg holds:
  - the op codes
  - the host FSM state enum
  - the TMS preamble/postamble constants (reset, DR, IR)
  - MAX_LEN
- Sub-module nios_jtag_tck_gen: a divider counter producing tck, rise_tick and fall_tick with an enable input. Everything else is one FSM, a bit counter and two shift registers in nios_jtag_tap_master.

## Test plan
- Bench TAP model (IEEE 1149.1 16-state, 2-bit IR, 38-bit DR), CLK_DIV=2:
  - Release reset, then DR scan len=8 data=0xA5. Required: reset preamble auto-prepended, 6+13=19 TCKs, latency 1+4*19=77 clks; model DR receives 0xA5; rsp_data equals the model's captured value.
  - IR scan len=2 data=0x3 after a TAP reset. Required: 8 TCKs, model IR=0b11, state ends Run-Test/Idle, tms=0.
  - DR scan len=38 with a loopback bypass model (1-bit DR) and data=0x2A. Required: rsp_data[0]=0 (capture bit), rsp_data[k]=cmd_data[k-1].
- Op 3 with len=0: rsp_valid one cycle after accept, tck never toggles. Op 3 with len=5: 5 TCKs with TMS=0.
- cmd_len=0 and cmd_len=100 on a DR scan: 1 and 64 shift TCKs respectively. cmd_valid held high during a busy command: no second accept until after rsp_valid.
- Assert reset mid-shift of a 32-bit DR scan. Required: next cycle tck=0, tms=1, no rsp_valid; the next scan prepends the reset sequence.
